// File: rtl/multicycle_control_unit_pkg.sv
// Shared REDUX-V constants: opcodes, control-vector bit positions, FSM states
// and the routing predicates used to sequence each instruction class.
package multicycle_control_unit_pkg;

    localparam int OP_W = 4;

    localparam logic [3:0] OP_BRZR = 4'h0;
    localparam logic [3:0] OP_JI   = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_PUSH = 4'h5;
    localparam logic [3:0] OP_POP  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_ADD  = 4'h9;
    localparam logic [3:0] OP_SUB  = 4'hA;
    localparam logic [3:0] OP_AND  = 4'hB;
    localparam logic [3:0] OP_OR   = 4'hC;
    localparam logic [3:0] OP_XOR  = 4'hD;
    localparam logic [3:0] OP_SLR  = 4'hE;
    localparam logic [3:0] OP_SRR  = 4'hF;

    // Bit positions inside the control vector, MSB first.
    localparam int SIG_BR  = 9;
    localparam int SIG_RA  = 8;
    localparam int SIG_J   = 7;
    localparam int SIG_RE  = 6;
    localparam int SIG_DM  = 5;
    localparam int SIG_WE  = 4;
    localparam int SIG_SE  = 3;
    localparam int SIG_SP  = 2;
    localparam int SIG_SPR = 1;
    localparam int SIG_RD  = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_e;

    function automatic logic is_mem(input logic [OP_W-1:0] op);
        return (op == OP_LD) || (op == OP_ST) || (op == OP_PUSH) || (op == OP_POP);
    endfunction

    function automatic logic is_branch(input logic [OP_W-1:0] op);
        return (op == OP_BRZR) || (op == OP_JI);
    endfunction

    // Everything except branches and stores ends with a register write.
    function automatic logic writes_rf(input logic [OP_W-1:0] op);
        return !(is_branch(op) || (op == OP_ST) || (op == OP_PUSH));
    endfunction

endpackage

// File: rtl/multicycle_control_unit_decode.sv
// Combinational opcode -> control vector / ALU op table, shared with the
// single-cycle control unit.
module control_decode
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP     = 4,
    parameter int ULA_OP = 3,
    parameter int SIG    = 10
) (
    input  logic [OP-1:0]     op_i,
    output logic [SIG-1:0]    signals_o,
    output logic [ULA_OP-1:0] ula_op_o
);

    always_comb begin
        signals_o = '0;
        ula_op_o  = op_i[ULA_OP-1:0];
        case (op_i)
            OP_BRZR: begin
                signals_o[SIG_BR] = 1'b1;
                signals_o[SIG_RA] = 1'b1;
            end
            OP_JI: signals_o[SIG_J] = 1'b1;
            OP_LD: begin
                signals_o[SIG_RA] = 1'b1;
                signals_o[SIG_RE] = 1'b1;
                signals_o[SIG_DM] = 1'b1;
            end
            OP_ST: signals_o[SIG_WE] = 1'b1;
            OP_ADDI: begin
                signals_o[SIG_SE] = 1'b1;
                signals_o[SIG_RE] = 1'b1;
                ula_op_o          = OP_ADD[ULA_OP-1:0];
            end
            OP_PUSH: begin
                signals_o[SIG_RA]  = 1'b1;
                signals_o[SIG_RE]  = 1'b1;
                signals_o[SIG_WE]  = 1'b1;
                signals_o[SIG_DM]  = 1'b1;
                signals_o[SIG_SP]  = 1'b1;
                signals_o[SIG_SPR] = 1'b1;
            end
            OP_POP: begin
                signals_o[SIG_RA] = 1'b1;
                signals_o[SIG_RE] = 1'b1;
                signals_o[SIG_DM] = 1'b1;
                signals_o[SIG_SP] = 1'b1;
            end
            OP_MOV: begin
                signals_o[SIG_RA] = 1'b1;
                signals_o[SIG_RE] = 1'b1;
                signals_o[SIG_RD] = 1'b1;
            end
            // Register-register ALU group.
            default: begin
                signals_o[SIG_RA] = 1'b1;
                signals_o[SIG_RE] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle REDUX-V sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded
// req/ack handshakes to instruction and data memory and a sticky timeout fault.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int OP       = 4,
    parameter int ULA_OP   = 3,
    parameter int SIG      = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [OP-1:0]     op,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              ir_we,
    output logic              rf_we,
    output logic              dm_we,
    output logic              pc_we,
    output logic [SIG-1:0]    signals,
    output logic [ULA_OP-1:0] ula_op,
    output logic              fault
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_e          state_q, state_d;
    logic [OP-1:0]   op_q, op_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [SIG-1:0]  dec_sig;
    logic            wait_max;
    state_e          end_state;

    control_decode #(.OP(OP), .ULA_OP(ULA_OP), .SIG(SIG)) u_decode (
        .op_i      (op_q),
        .signals_o (dec_sig),
        .ula_op_o  (ula_op)
    );

    assign wait_max  = (wait_q == WW'(MAX_WAIT));
    assign end_state = run ? S_FETCH : S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // wait_d defaults to zero so the counter is clear on every entry to a
    // handshake state; it only counts while a request is pending.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_d   = '0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        pc_we    = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    op_d    = op;
                    state_d = S_DECODE;
                end else if (wait_max) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: state_d = is_mem(op_q) ? S_MEM : S_EXEC;
            S_EXEC: begin
                if (is_branch(op_q)) begin
                    pc_we   = 1'b1;
                    state_d = end_state;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dm_we    = dec_sig[SIG_WE];
                if (dmem_ack) begin
                    if (writes_rf(op_q)) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = end_state;
                    end
                end else if (wait_max) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = end_state;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    assign signals = ((state_q == S_IDLE) || (state_q == S_FETCH) || (state_q == S_FAULT))
                     ? '0 : dec_sig;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: opcode table sweep, randomized ack delays
// against an instruction-level model, and hand sequences for reset/run/timeout.
module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst, run, imem_ack, dmem_ack;
    logic [3:0] op;
    logic       imem_req, dmem_req, ir_we, rf_we, dm_we, pc_we, fault;
    logic [9:0] signals;
    logic [2:0] ula_op;
    logic       imem_req3, dmem_req3, ir_we3, rf_we3, dm_we3, pc_we3, fault3;
    logic [9:0] signals3;
    logic [2:0] ula_op3;

    multicycle_control_unit #(.OP(4), .ULA_OP(3), .SIG(10), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .run(run), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_we(ir_we), .rf_we(rf_we),
        .dm_we(dm_we), .pc_we(pc_we), .signals(signals), .ula_op(ula_op), .fault(fault));

    multicycle_control_unit #(.OP(4), .ULA_OP(3), .SIG(10), .MAX_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .run(run), .op(op), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req3), .dmem_req(dmem_req3), .ir_we(ir_we3), .rf_we(rf_we3),
        .dm_we(dm_we3), .pc_we(pc_we3), .signals(signals3), .ula_op(ula_op3), .fault(fault3));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [9:0] sig;
        logic [2:0] ula;
        int         cyc;
    } vec_t;
    vec_t vecs[16];

    function automatic bit mem_class(input logic [3:0] o);
        return (o == 4'h2) || (o == 4'h3) || (o == 4'h5) || (o == 4'h6);
    endfunction
    function automatic bit store_class(input logic [3:0] o);
        return (o == 4'h3) || (o == 4'h5);
    endfunction
    function automatic bit rf_class(input logic [3:0] o);
        return !((o == 4'h0) || (o == 4'h1) || store_class(o));
    endfunction

    // Runs one instruction with the given fetch/data ack delays and checks
    // latency, strobe counts/placement and the decoded vector.
    task automatic run_instr(input logic [3:0] o, input int fd, input int md);
        int cyc = 0, fcnt = 0, mcnt = 0, ir_n = 0, ir_at = -1, rf_n = 0, rf_at = -1;
        int dreq_n = 0, dreq_last = -1, dmwe_n = 0, sig_bad = 0, pc_at = -1;
        bit started = 0;
        bit m = mem_class(o);
        for (int k = 0; k < 80 && pc_at < 0; k++) begin
            @(negedge clk);
            imem_ack = imem_req && (fcnt == fd);
            dmem_ack = dmem_req && (mcnt == md);
            op = imem_ack ? o : 4'($urandom);
            if (imem_req) fcnt++;
            if (dmem_req) mcnt++;
            #1;
            if (started || imem_req) begin
                started = 1;
                cyc++;
                if (ir_we) begin ir_n++; ir_at = cyc; end
                if (rf_we) begin rf_n++; rf_at = cyc; end
                if (imem_req) begin
                    if (signals !== 10'h0) sig_bad++;
                end else if (signals !== vecs[o].sig || ula_op !== vecs[o].ula) begin
                    sig_bad++;
                end
                if (dmem_req) begin
                    dreq_n++;
                    dreq_last = cyc;
                    if (dm_we) dmwe_n++;
                end else if (dm_we) begin
                    sig_bad++;
                end
                if (pc_we) pc_at = cyc;
            end
        end
        chk($sformatf("op%0h done_before_timeout", o), 32'(pc_at >= 0), 32'd1);
        chk($sformatf("op%0h cycles fd=%0d md=%0d", o, fd, md), cyc,
            vecs[o].cyc + fd + (m ? md : 0));
        chk($sformatf("op%0h ir_we_count", o), ir_n, 1);
        chk($sformatf("op%0h ir_we_cycle", o), ir_at, fd + 1);
        chk($sformatf("op%0h decode_vector", o), sig_bad, 0);
        chk($sformatf("op%0h rf_we_count", o), rf_n, rf_class(o) ? 1 : 0);
        chk($sformatf("op%0h dmem_req_cycles", o), dreq_n, m ? md + 1 : 0);
        chk($sformatf("op%0h dm_we_cycles", o), dmwe_n, store_class(o) ? md + 1 : 0);
        if (rf_class(o)) chk($sformatf("op%0h rf_we_with_pc_we", o), rf_at, pc_at);
        if (m && rf_class(o)) chk($sformatf("op%0h rf_after_ack", o), rf_at, dreq_last + 1);
        if (store_class(o)) chk($sformatf("op%0h pc_on_ack", o), pc_at, dreq_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vecs[0]  = '{4'h0, 10'h300, 3'd0, 3};
        vecs[1]  = '{4'h1, 10'h080, 3'd1, 3};
        vecs[2]  = '{4'h2, 10'h160, 3'd2, 4};
        vecs[3]  = '{4'h3, 10'h010, 3'd3, 3};
        vecs[4]  = '{4'h4, 10'h048, 3'd1, 4};
        vecs[5]  = '{4'h5, 10'h176, 3'd5, 3};
        vecs[6]  = '{4'h6, 10'h164, 3'd6, 4};
        vecs[7]  = '{4'h7, 10'h141, 3'd7, 4};
        vecs[8]  = '{4'h8, 10'h140, 3'd0, 4};
        vecs[9]  = '{4'h9, 10'h140, 3'd1, 4};
        vecs[10] = '{4'hA, 10'h140, 3'd2, 4};
        vecs[11] = '{4'hB, 10'h140, 3'd3, 4};
        vecs[12] = '{4'hC, 10'h140, 3'd4, 4};
        vecs[13] = '{4'hD, 10'h140, 3'd5, 4};
        vecs[14] = '{4'hE, 10'h140, 3'd6, 4};
        vecs[15] = '{4'hF, 10'h140, 3'd7, 4};

        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; op = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {imem_req, dmem_req, ir_we, rf_we, dm_we, pc_we, fault, signals, ula_op}, 0);
        chk("reset_outputs_mw3", {imem_req3, dmem_req3, ir_we3, rf_we3, dm_we3, pc_we3, fault3, signals3, ula_op3}, 0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;

        for (int i = 0; i < 16; i++) run_instr(vecs[i].op, 0, 0);
        run_instr(OP_LD, 0, 5);
        run_instr(OP_PUSH, 2, 3);
        for (int i = 0; i < 40; i++)
            run_instr(4'($urandom_range(15)), int'($urandom_range(4)), int'($urandom_range(4)));

        // Asynchronous reset in the middle of a data handshake.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            imem_ack = imem_req; dmem_ack = 1'b0; op = OP_LD;
            #1;
            found = dmem_req;
        end
        chk("reached_mem", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_mem_outputs", {imem_req, dmem_req, ir_we, rf_we, dm_we, pc_we, fault, signals, ula_op}, 0);
        run = 1'b0; imem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
        #1 chk("idle_after_release", imem_req, 0);
        @(negedge clk);
        #1 chk("fetch_after_release", imem_req, 1);

        // run drops during EXEC of ADD: WB completes, then park in IDLE.
        @(negedge clk);
        imem_ack = 1'b1; op = OP_ADD;
        #1 chk("add_ir_we", ir_we, 1);
        @(negedge clk);
        imem_ack = 1'b0; op = 4'($urandom);
        @(negedge clk);
        #1 chk("add_exec_signals", {rf_we, pc_we, signals}, {2'b00, 10'h140});
        run = 1'b0;
        @(negedge clk);
        #1 chk("add_wb_strobes", {rf_we, pc_we}, 2'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk($sformatf("parked_idle_%0d", k), {imem_req, signals, pc_we}, 0);
        end

        // MAX_WAIT=3: ack on the 4th fetch cycle accepted, then a timeout.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = (i == 3); op = OP_ADD;
            #1 chk($sformatf("mw3_fetch_%0d", i), {imem_req3, ir_we3}, {1'b1, 1'(i == 3)});
        end
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            #1 found = imem_req3;
        end
        chk("mw3_refetch", 32'(found), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("mw3_waiting_%0d", i), {imem_req3, fault3}, 2'b10);
        end
        @(negedge clk);
        #1 chk("mw3_fault", {fault3, imem_req3}, 2'b10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            #1 chk($sformatf("mw3_fault_sticky_%0d", i),
                   {fault3, imem_req3, dmem_req3, pc_we3, ir_we3, signals3}, {1'b1, 14'h0});
        end
        rst = 1'b1;
        #1 chk("mw3_fault_cleared", fault3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
